// File: rtl/wb_select_stage.sv
// Registered write-back select stage: picks the register-file write data from packed sources,
// waits a cycle for synchronous DRAM data on loads, and hands the result on via valid/ready.
// Optional forwarding outputs are enabled by defining WB_FWD_EN.
module wb_select_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_SRC  = 5,
  parameter int SEL_W    = 3,
  parameter int LOAD_SEL = 3,
  parameter int REG_AW   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          wd_sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [REG_AW-1:0]         in_rd,
  input  logic                      in_we,
  input  logic [DATA_W-1:0]         dram_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_we,
  output logic [REG_AW-1:0]         out_rd,
  output logic [DATA_W-1:0]         out_wd,
  output logic                      fwd_valid,
  output logic                      fwd_pending,
  output logic [REG_AW-1:0]         fwd_rd,
  output logic [DATA_W-1:0]         fwd_wd
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    LOAD_WAIT = 2'd1,
    FULL      = 2'd2
  } state_t;

  state_t            state;
  logic              pend_we;
  logic              accept;
  logic              eff_we;
  logic              is_load;
  logic [DATA_W-1:0] sel_data;

  // Selects outside the populated source range resolve to zero rather than holding old data.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(wd_sel) == i) begin
        sel_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign in_ready = (state == EMPTY) | ((state == FULL) & out_ready);
  assign accept   = in_valid & in_ready;
  assign eff_we   = in_we & (in_rd != '0);
  assign is_load  = (wd_sel == SEL_W'(LOAD_SEL));

  // The load's write enable is parked in pend_we so out_we stays 0 until the result is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_we    <= 1'b0;
      out_rd    <= '0;
      out_wd    <= '0;
      pend_we   <= 1'b0;
    end else begin
      unique case (state)
        EMPTY, FULL: begin
          if (accept) begin
            out_rd <= in_rd;
            if (is_load) begin
              state     <= LOAD_WAIT;
              out_valid <= 1'b0;
              out_we    <= 1'b0;
              pend_we   <= eff_we;
            end else begin
              state     <= FULL;
              out_valid <= 1'b1;
              out_we    <= eff_we;
              out_wd    <= sel_data;
            end
          end else if ((state == FULL) && out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_we    <= 1'b0;
          end
        end
        LOAD_WAIT: begin
          state     <= FULL;
          out_valid <= 1'b1;
          out_we    <= pend_we;
          out_wd    <= dram_rdata;
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          out_we    <= 1'b0;
        end
      endcase
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid   = out_valid & out_we;
  assign fwd_pending = (state == LOAD_WAIT) & pend_we;
  assign fwd_rd      = out_rd;
  assign fwd_wd      = out_wd;
`else
  assign fwd_valid   = 1'b0;
  assign fwd_pending = 1'b0;
  assign fwd_rd      = '0;
  assign fwd_wd      = '0;
`endif

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: directed scenarios plus a randomized run scored
// against a transaction-level queue model.
module tb_wb_select_stage;

  localparam int DATA_W = 32;
  localparam int NUM_SRC = 5;
  localparam int SEL_W = 3;
  localparam int REG_AW = 5;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                      clk;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_W-1:0]          wd_sel;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [REG_AW-1:0]         in_rd;
  logic                      in_we;
  logic [DATA_W-1:0]         dram_rdata;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_we;
  logic [REG_AW-1:0]         out_rd;
  logic [DATA_W-1:0]         out_wd;
  logic                      fwd_valid;
  logic                      fwd_pending;
  logic [REG_AW-1:0]         fwd_rd;
  logic [DATA_W-1:0]         fwd_wd;

  int checks = 0;
  int errors = 0;

  wb_select_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .wd_sel(wd_sel),
    .src_data(src_data), .in_rd(in_rd), .in_we(in_we), .dram_rdata(dram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we), .out_rd(out_rd),
    .out_wd(out_wd), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_rd(fwd_rd),
    .fwd_wd(fwd_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference select rule: in-range selects pick a slice, anything else reads zero.
  function automatic logic [DATA_W-1:0] ref_sel(input int sel, input logic [NUM_SRC*DATA_W-1:0] src);
    if (sel < NUM_SRC) return src[sel*DATA_W +: DATA_W];
    return '0;
  endfunction

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (out_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %0b exp 0", out_we); end
    checks++; if (out_rd !== '0) begin errors++; $display("[TB] FAIL reset_rd got %0d exp 0", out_rd); end
    checks++; if (out_wd !== '0) begin errors++; $display("[TB] FAIL reset_wd got %h exp 0", out_wd); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++; if ({fwd_valid, fwd_pending, fwd_rd, fwd_wd} !== '0) begin errors++; $display("[TB] FAIL reset_fwd got %0b%0b %0d %h exp all 0", fwd_valid, fwd_pending, fwd_rd, fwd_wd); end
  endtask

  task automatic test_alu_basic();
    in_valid = 1'b1; wd_sel = 3'd1; src_data[1*DATA_W +: DATA_W] = 32'h0000_1234;
    in_rd = 5'd5; in_we = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL alu_in_ready got %0b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL alu_valid got %0b exp 1", out_valid); end
    checks++; if (out_we !== 1'b1) begin errors++; $display("[TB] FAIL alu_we got %0b exp 1", out_we); end
    checks++; if (out_rd !== 5'd5) begin errors++; $display("[TB] FAIL alu_rd got %0d exp 5", out_rd); end
    checks++; if (out_wd !== 32'h0000_1234) begin errors++; $display("[TB] FAIL alu_wd got %h exp 00001234", out_wd); end
    checks++; if (fwd_valid !== FWD) begin errors++; $display("[TB] FAIL alu_fwd_valid got %0b exp %0b", fwd_valid, FWD); end
    step();
    checks++; if (out_valid !== 1'b0 || out_we !== 1'b0) begin errors++; $display("[TB] FAIL alu_drain got valid %0b we %0b exp 0 0", out_valid, out_we); end
  endtask

  task automatic test_load();
    in_valid = 1'b1; wd_sel = 3'd3; in_rd = 5'd7; in_we = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; dram_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL load_wait_in_ready got %0b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0 || out_we !== 1'b0) begin errors++; $display("[TB] FAIL load_wait_out got valid %0b we %0b exp 0 0", out_valid, out_we); end
    checks++; if (fwd_pending !== FWD) begin errors++; $display("[TB] FAIL load_pending got %0b exp %0b", fwd_pending, FWD); end
    step();
    dram_rdata = 32'h0BAD_F00D;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL load_valid got %0b exp 1", out_valid); end
    checks++; if (out_wd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL load_wd got %h exp deadbeef", out_wd); end
    checks++; if (out_rd !== 5'd7 || out_we !== 1'b1) begin errors++; $display("[TB] FAIL load_rd_we got %0d %0b exp 7 1", out_rd, out_we); end
    checks++; if (fwd_pending !== 1'b0) begin errors++; $display("[TB] FAIL load_pending_clear got %0b exp 0", fwd_pending); end
    step();
  endtask

  task automatic test_stall();
    in_valid = 1'b1; wd_sel = 3'd2; src_data[2*DATA_W +: DATA_W] = 32'hAAAA_0002;
    in_rd = 5'd9; in_we = 1'b1; out_ready = 1'b0;
    step();
    wd_sel = 3'd4; src_data[4*DATA_W +: DATA_W] = 32'hBBBB_0004; in_rd = 5'd10;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready cycle %0d got %0b exp 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_wd !== 32'hAAAA_0002 || out_rd !== 5'd9) begin errors++; $display("[TB] FAIL stall_hold cycle %0d got %0b %h %0d exp 1 aaaa0002 9", c, out_valid, out_wd, out_rd); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_ready got %0b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_wd !== 32'hBBBB_0004 || out_rd !== 5'd10) begin errors++; $display("[TB] FAIL stall_next got %0b %h %0d exp 1 bbbb0004 10", out_valid, out_wd, out_rd); end
    step();
  endtask

  task automatic test_x0_and_oob();
    in_valid = 1'b1; wd_sel = 3'd0; src_data[0 +: DATA_W] = 32'h5555_AAAA;
    in_rd = 5'd0; in_we = 1'b1; out_ready = 1'b1;
    step();
    wd_sel = 3'd6; in_rd = 5'd3;
    #1;
    checks++; if (out_valid !== 1'b1 || out_we !== 1'b0) begin errors++; $display("[TB] FAIL x0_we got valid %0b we %0b exp 1 0", out_valid, out_we); end
    checks++; if (out_wd !== 32'h5555_AAAA) begin errors++; $display("[TB] FAIL x0_wd got %h exp 5555aaaa", out_wd); end
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("[TB] FAIL x0_fwd_valid got %0b exp 0", fwd_valid); end
    step();
    wd_sel = 3'd5; in_rd = 5'd4;
    #1;
    checks++; if (out_wd !== '0 || out_we !== 1'b1 || out_rd !== 5'd3) begin errors++; $display("[TB] FAIL oob6 got %h %0b %0d exp 0 1 3", out_wd, out_we, out_rd); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_wd !== '0 || out_rd !== 5'd4) begin errors++; $display("[TB] FAIL oob5 got %0b %h %0d exp 1 0 4", out_valid, out_wd, out_rd); end
    step();
  endtask

  task automatic test_back_to_back();
    int sels[4] = '{0, 1, 2, 4};
    for (int i = 0; i < NUM_SRC; i++) src_data[i*DATA_W +: DATA_W] = 32'hC0DE_0000 + 32'(i);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; wd_sel = 3'(sels[k]); in_rd = 5'(k + 1); in_we = 1'b1; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready %0d got %0b exp 1", k, in_ready); end
      if (k > 0) begin
        checks++; if (out_valid !== 1'b1 || out_wd !== 32'hC0DE_0000 + 32'(sels[k-1])) begin errors++; $display("[TB] FAIL b2b_result %0d got %0b %h exp 1 %h", k, out_valid, out_wd, 32'hC0DE_0000 + 32'(sels[k-1])); end
      end
      step();
    end
    wd_sel = 3'd3; in_rd = 5'd11;
    #1;
    checks++; if (out_valid !== 1'b1 || out_wd !== 32'hC0DE_0004) begin errors++; $display("[TB] FAIL b2b_last got %0b %h exp 1 c0de0004", out_valid, out_wd); end
    step();
    wd_sel = 3'd1; in_rd = 5'd12; dram_rdata = 32'h1111_2222;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_bubble got ready %0b valid %0b exp 0 0", in_ready, out_valid); end
    step();
    dram_rdata = 32'h0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_wd !== 32'h1111_2222 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_load got %0b %h ready %0b exp 1 11112222 1", out_valid, out_wd, in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_wd !== 32'hC0DE_0001 || out_rd !== 5'd12) begin errors++; $display("[TB] FAIL b2b_after_load got %0b %h %0d exp 1 c0de0001 12", out_valid, out_wd, out_rd); end
    step();
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; wd_sel = 3'd2; src_data[2*DATA_W +: DATA_W] = 32'h0000_0077;
    in_rd = 5'd6; in_we = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_valid got %0b exp 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({out_valid, out_we, out_rd, out_wd} !== '0) begin errors++; $display("[TB] FAIL arst_full got %0b %0b %0d %h exp all 0", out_valid, out_we, out_rd, out_wd); end
    checks++; if ({fwd_valid, fwd_pending, fwd_rd, fwd_wd} !== '0) begin errors++; $display("[TB] FAIL arst_full_fwd got nonzero %0b %0b exp 0", fwd_valid, fwd_pending); end
    #1 rst = 1'b0;
    step();
    in_valid = 1'b1; wd_sel = 3'd3; in_rd = 5'd9; out_ready = 1'b1;
    step();
    in_valid = 1'b0; dram_rdata = 32'hFFFF_0000;
    #2 rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || fwd_pending !== 1'b0 || out_rd !== '0) begin errors++; $display("[TB] FAIL arst_load got ready %0b valid %0b pend %0b rd %0d exp 1 0 0 0", in_ready, out_valid, fwd_pending, out_rd); end
    #1 rst = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_dropped got %0b exp 0", out_valid); end
    in_valid = 1'b1; wd_sel = 3'd1; src_data[1*DATA_W +: DATA_W] = 32'h0000_4242; in_rd = 5'd2; in_we = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_wd !== 32'h0000_4242 || out_rd !== 5'd2 || out_we !== 1'b1) begin errors++; $display("[TB] FAIL arst_first got %0b %h %0d %0b exp 1 4242 2 1", out_valid, out_wd, out_rd, out_we); end
    step();
  endtask

  // Transaction-level model: a queue of results owed downstream, plus a one-cycle load wait flag.
  task automatic test_random(input int n);
    logic [DATA_W-1:0] q_wd[$];
    logic [REG_AW-1:0] q_rd[$];
    logic              q_we[$];
    bit                load_wait;
    bit                exp_valid;
    bit                exp_ready;
    logic [DATA_W-1:0] load_val;
    load_wait = 1'b0;
    load_val = '0;
    for (int c = 0; c < n; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      wd_sel = 3'($urandom_range(0, 7));
      for (int i = 0; i < NUM_SRC; i++) src_data[i*DATA_W +: DATA_W] = $urandom;
      in_rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      in_we = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      dram_rdata = load_wait ? load_val : $urandom;
      #1;
      exp_valid = (q_wd.size() > 0) && !load_wait;
      exp_ready = !load_wait && ((q_wd.size() == 0) || out_ready);
      checks++; if (in_ready !== exp_ready) begin errors++; $display("[TB] FAIL rnd_in_ready cycle %0d got %0b exp %0b", c, in_ready, exp_ready); end
      checks++; if (out_valid !== exp_valid) begin errors++; $display("[TB] FAIL rnd_out_valid cycle %0d got %0b exp %0b", c, out_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (out_we !== q_we[0] || out_rd !== q_rd[0] || out_wd !== q_wd[0]) begin errors++; $display("[TB] FAIL rnd_result cycle %0d got %0b %0d %h exp %0b %0d %h", c, out_we, out_rd, out_wd, q_we[0], q_rd[0], q_wd[0]); end
        checks++; if (fwd_valid !== (FWD & q_we[0])) begin errors++; $display("[TB] FAIL rnd_fwd_valid cycle %0d got %0b exp %0b", c, fwd_valid, FWD & q_we[0]); end
        if (FWD) begin
          checks++; if (fwd_rd !== q_rd[0] || fwd_wd !== q_wd[0]) begin errors++; $display("[TB] FAIL rnd_fwd_data cycle %0d got %0d %h exp %0d %h", c, fwd_rd, fwd_wd, q_rd[0], q_wd[0]); end
        end
      end else begin
        checks++; if (out_we !== 1'b0 || fwd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_idle_we cycle %0d got %0b %0b exp 0 0", c, out_we, fwd_valid); end
      end
      checks++; if (fwd_pending !== (FWD & load_wait & ((q_we.size() > 0) ? q_we[0] : 1'b0))) begin errors++; $display("[TB] FAIL rnd_pending cycle %0d got %0b", c, fwd_pending); end
      load_wait = 1'b0;
      if (exp_valid && out_ready) begin
        void'(q_wd.pop_front()); void'(q_rd.pop_front()); void'(q_we.pop_front());
      end
      if (in_valid && exp_ready) begin
        q_rd.push_back(in_rd);
        q_we.push_back(in_we && (in_rd != 0));
        if (wd_sel == 3'd3) begin
          load_val = $urandom;
          load_wait = 1'b1;
          q_wd.push_back(load_val);
        end else begin
          q_wd.push_back(ref_sel(int'(wd_sel), src_data));
        end
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; wd_sel = '0; src_data = '0; in_rd = '0; in_we = 1'b0;
    dram_rdata = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    $display("[TB] directed scenarios");
    test_alu_basic();
    test_load();
    test_stall();
    test_x0_and_oob();
    test_back_to_back();
    test_async_reset();
    $display("[TB] randomized run");
    test_random(2000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
